// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control FSM: opcodes, ALU/mux
// encodings, the state enum and the control word driven by the decoder.
package multicycle_ctrl_pkg;

  // Instruction opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // aluop encodings consumed by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b01;

  // ALU operand B select
  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM state encoding (visible on the debug port)
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  // Full set of datapath controls produced for one state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = ctrl_word_t'(17'd0);

  // True for every opcode the FSM knows how to execute
  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Dispatch target out of DECODE; unknown opcodes return to FETCH
  function automatic state_t decode_dispatch(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = S_EXEC;
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_BEQ:       nxt = S_BRANCH;
      OP_J:         nxt = S_JUMP;
      OP_ADDI:      nxt = S_ADDIEX;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Purely combinational state-to-control-word decoder. The only non-state
// input is the effective memory-ready, which gates the FETCH strobes and the
// store retirement pulse.
module multicycle_ctrl_dec
  import multicycle_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ready,
  output ctrl_word_t o_ctrl
);

  // Moore decode of the datapath controls; anything not named stays 0
  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.iord      = 1'b0;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = ALUB_FOUR;
        o_ctrl.aluop     = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Branch target precompute: PC + (imm << 2)
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = ALUB_IMM_SH;
        o_ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_IMM;
        o_ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_dst    = 1'b0;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        // Strobe held through wait states; the store retires on ready
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_REG;
        o_ctrl.aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.mem_to_reg = 1'b0;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = ALUB_REG;
        o_ctrl.aluop         = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_IMM;
        o_ctrl.aluop     = ALUOP_ADD;
      end
      S_ADDIWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b0;
        o_ctrl.mem_to_reg = 1'b0;
        o_ctrl.instr_done = 1'b1;
      end
      default: begin
        o_ctrl = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU. State register + next-state logic
// live here; the control word comes from multicycle_ctrl_dec. ir_write and
// pc_write are additionally gated by reset so no fetch side effect occurs
// while the block is held in reset.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_illegal_op;
  logic       w_mem_ready;
  logic       w_zero_unused;
  ctrl_word_t w_ctrl;

  // With wait states disabled every memory access completes immediately
  assign w_mem_ready = (MEM_WAIT_EN != 1'b0) ? mem_ready : 1'b1;

  // zero is consumed by the datapath (pc_write_cond & zero), not the FSM
  assign w_zero_unused = zero;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; memory states hold until the access completes
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next_state = decode_dispatch(opcode);
      S_MEMADR: w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next_state = w_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next_state = S_FETCH;
      S_MEMWR:  w_next_state = w_mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ALUWB:  w_next_state = S_FETCH;
      S_BRANCH: w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      S_ADDIEX: w_next_state = S_ADDIWB;
      S_ADDIWB: w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal_op <= 1'b0;
    end else if ((r_state == S_DECODE) && !is_legal_op(opcode)) begin
      r_illegal_op <= 1'b1;
    end else begin
      r_illegal_op <= r_illegal_op;
    end
  end

  multicycle_ctrl_dec u_dec (
    .i_state     (r_state),
    .i_mem_ready (w_mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Output decode: drive ports from the control word, gating fetch strobes in reset
  always_comb begin
    pc_write      = w_ctrl.pc_write & ~rst;
    ir_write      = w_ctrl.ir_write & ~rst;
    pc_write_cond = w_ctrl.pc_write_cond;
    iord          = w_ctrl.iord;
    mem_read      = w_ctrl.mem_read;
    mem_write     = w_ctrl.mem_write;
    mem_to_reg    = w_ctrl.mem_to_reg;
    reg_dst       = w_ctrl.reg_dst;
    reg_write     = w_ctrl.reg_write;
    alu_src_a     = w_ctrl.alu_src_a;
    alu_src_b     = w_ctrl.alu_src_b;
    aluop         = w_ctrl.aluop;
    pc_source     = w_ctrl.pc_source;
    instr_done    = w_ctrl.instr_done;
    state         = r_state;
    illegal_op    = r_illegal_op;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Outputs are packed into a
// 17-bit control vector and compared against hand-written per-state values.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, aluop, pc_source;
  logic [3:0] state;
  logic       illegal_op, instr_done;

  int checks = 0;
  int errors = 0;
  int irw_cnt = 0;
  int done_cnt = 0;
  int snap_irw;
  int snap_done;

  // Packed view: pcw pwc iord mrd mwr irw m2r rdst rw asa asb aop psrc done
  logic [16:0] cw;
  assign cw = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop,
               pc_source, instr_done};

  localparam logic [16:0] CW_F_GO   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] CW_F_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] CW_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] CW_MADR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] CW_MRD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] CW_MWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
  localparam logic [16:0] CW_MWR_GO = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
  localparam logic [16:0] CW_MWR_W  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] CW_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_01_00_0;
  localparam logic [16:0] CW_ALUWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1;
  localparam logic [16:0] CW_BR     = 17'b0_1_0_0_0_0_0_0_0_1_00_10_01_1;
  localparam logic [16:0] CW_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;
  localparam logic [16:0] CW_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe cycles mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (ir_write === 1'b1) irw_cnt = irw_cnt + 1;
    if (instr_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at edge+1 with inputs set; checks state and controls, then advances one clock
  task automatic step(input string tag, input logic [3:0] st, input logic [16:0] exp_cw);
    #1;
    chk({tag, "_state"}, {13'd0, state}, {13'd0, st});
    chk({tag, "_cw"}, cw, exp_cw);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    opcode = 6'b000000;
    zero = 1'b0;
    mem_ready = 1'b1;
    #1;
    // In reset: FETCH defaults, fetch strobes gated even with mem_ready=1
    chk("rst_state", {13'd0, state}, 17'd0);
    chk("rst_cw", cw, CW_F_WAIT);
    chk("rst_illegal", {16'd0, illegal_op}, 17'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // R-type: 0,1,6,7,0
    opcode = 6'b000000;
    snap_done = done_cnt;
    step("rt_f", 4'd0, CW_F_GO);
    step("rt_d", 4'd1, CW_DEC);
    step("rt_ex", 4'd6, CW_EXEC);
    step("rt_wb", 4'd7, CW_ALUWB);
    chk("rt_done_cnt", 17'(done_cnt - snap_done), 17'd1);

    // lw with 2 FETCH waits and 3 MEMRD waits: 10 cycles
    opcode = 6'b100011;
    snap_irw = irw_cnt;
    mem_ready = 1'b0;
    step("lw_fw1", 4'd0, CW_F_WAIT);
    step("lw_fw2", 4'd0, CW_F_WAIT);
    mem_ready = 1'b1;
    step("lw_f", 4'd0, CW_F_GO);
    step("lw_d", 4'd1, CW_DEC);
    step("lw_adr", 4'd2, CW_MADR);
    mem_ready = 1'b0;
    step("lw_rw1", 4'd3, CW_MRD);
    step("lw_rw2", 4'd3, CW_MRD);
    step("lw_rw3", 4'd3, CW_MRD);
    mem_ready = 1'b1;
    step("lw_rd", 4'd3, CW_MRD);
    step("lw_wb", 4'd4, CW_MWB);
    chk("lw_irw_cnt", 17'(irw_cnt - snap_irw), 17'd1);

    // sw: 0,1,2,5,0
    opcode = 6'b101011;
    step("sw_f", 4'd0, CW_F_GO);
    step("sw_d", 4'd1, CW_DEC);
    step("sw_adr", 4'd2, CW_MADR);
    step("sw_wr", 4'd5, CW_MWR_GO);

    // sw stalled in MEMWR, then asynchronous reset mid-cycle
    step("swr_f", 4'd0, CW_F_GO);
    step("swr_d", 4'd1, CW_DEC);
    step("swr_adr", 4'd2, CW_MADR);
    mem_ready = 1'b0;
    step("swr_w1", 4'd5, CW_MWR_W);
    step("swr_w2", 4'd5, CW_MWR_W);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", {13'd0, state}, 17'd0);
    chk("arst_mwr", {16'd0, mem_write}, 17'd0);
    chk("arst_illegal", {16'd0, illegal_op}, 17'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst_f", 4'd0, CW_F_WAIT);
    mem_ready = 1'b1;

    // beq with zero=1 then zero=0: same sequence 0,1,8,0
    opcode = 6'b000100;
    zero = 1'b1;
    step("beq1_f", 4'd0, CW_F_GO);
    step("beq1_d", 4'd1, CW_DEC);
    step("beq1_br", 4'd8, CW_BR);
    zero = 1'b0;
    step("beq0_f", 4'd0, CW_F_GO);
    step("beq0_d", 4'd1, CW_DEC);
    step("beq0_br", 4'd8, CW_BR);

    // addi: 0,1,10,11,0
    opcode = 6'b001000;
    step("addi_f", 4'd0, CW_F_GO);
    step("addi_d", 4'd1, CW_DEC);
    step("addi_ex", 4'd10, CW_MADR);
    step("addi_wb", 4'd11, CW_ADDIWB);

    // Illegal opcode: DECODE then FETCH, sticky flag, no retirement pulse
    opcode = 6'b111111;
    snap_done = done_cnt;
    chk("ill_pre", {16'd0, illegal_op}, 17'd0);
    step("ill_f", 4'd0, CW_F_GO);
    step("ill_d", 4'd1, CW_DEC);
    chk("ill_set", {16'd0, illegal_op}, 17'd1);
    chk("ill_no_done", 17'(done_cnt - snap_done), 17'd0);

    // Following jump: 0,1,9,0; flag stays set
    opcode = 6'b000010;
    step("j_f", 4'd0, CW_F_GO);
    step("j_d", 4'd1, CW_DEC);
    step("j_j", 4'd9, CW_JUMP);
    step("j_back", 4'd0, CW_F_GO);
    chk("ill_sticky", {16'd0, illegal_op}, 17'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
